// File: rtl/sr_flag_pkg.sv
// rtl/sr_flag_pkg.sv - shared op encodings and FSM state type for the SR flag arbiter
package sr_flag_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD,
        ST_CHECK
    } state_t;

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - single SR flag flop, synchronous reset to 0, set wins over reset input
module sr_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (s) begin
            r_q <= 1'b1;
        end else if (r) begin
            r_q <= 1'b0;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbiter sequencing set/clear/toggle ops onto a bank of SR flag cells
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int NFLAG = 8,
    localparam int IW    = $clog2(NFLAG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [2*NREQ-1:0]  op,
    input  logic [IW*NREQ-1:0] idx,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               busy,
    output logic [NFLAG-1:0]   flags,
    output logic               err
);

    localparam int PW = $clog2(NREQ);

    state_t            r_state;
    state_t            w_next;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_ack;
    logic              r_err;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_win;
    logic [IW-1:0]     r_idx;
    logic              r_s_lat;
    logic              r_r_lat;
    logic              r_exp;

    logic              w_any;
    logic [PW-1:0]     w_win;
    logic [1:0]        w_op;
    logic [IW-1:0]     w_idx;
    logic              w_set;
    logic              w_clr;
    logic              w_exp;
    logic              w_mis;
    logic [NFLAG-1:0]  w_s;
    logic [NFLAG-1:0]  w_r;
    logic [NFLAG-1:0]  w_q;
    logic [NFLAG-1:0]  w_qbar;

    // Round-robin search starting one past the last acknowledged requester.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && req[(int'(r_ptr) + i) % NREQ]) begin
                w_any = 1'b1;
                w_win = PW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    assign w_op  = op[2*int'(w_win) +: 2];
    assign w_idx = idx[IW*int'(w_win) +: IW];

    // Toggle is resolved against the current Q, so S and R are never both asserted.
    always_comb begin
        w_set = 1'b0;
        w_clr = 1'b0;
        w_exp = w_q[w_idx];
        case (w_op)
            OP_SET: begin
                w_set = 1'b1;
                w_exp = 1'b1;
            end
            OP_CLR: begin
                w_clr = 1'b1;
                w_exp = 1'b0;
            end
            OP_TGL: begin
                w_set = ~w_q[w_idx];
                w_clr = w_q[w_idx];
                w_exp = ~w_q[w_idx];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_any ? ST_DRIVE : ST_IDLE;
            ST_DRIVE: w_next = ST_HOLD;
            ST_HOLD:  w_next = ST_CHECK;
            ST_CHECK: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Grant stays up through the ack cycle; it is replaced or dropped on the next IDLE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_win   <= '0;
            r_idx   <= '0;
            r_s_lat <= 1'b0;
            r_r_lat <= 1'b0;
            r_exp   <= 1'b0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= NREQ'(1) << w_win;
                        r_win   <= w_win;
                        r_idx   <= w_idx;
                        r_s_lat <= w_set;
                        r_r_lat <= w_clr;
                        r_exp   <= w_exp;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                ST_CHECK: begin
                    r_ack <= r_gnt;
                    r_err <= w_mis;
                    r_ptr <= (int'(r_win) == NREQ - 1) ? '0 : r_win + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_mis = r_exp ? w_qbar[r_idx] : w_q[r_idx];
    assign w_s   = (r_state == ST_DRIVE && r_s_lat) ? (NFLAG'(1) << r_idx) : '0;
    assign w_r   = (r_state == ST_DRIVE && r_r_lat) ? (NFLAG'(1) << r_idx) : '0;

    for (genvar g = 0; g < NFLAG; g++) begin : g_cell
        sr_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .s    (w_s[g]),
            .r    (w_r[g]),
            .q    (w_q[g]),
            .qbar (w_qbar[g])
        );
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = (r_state != ST_IDLE);
    assign flags = w_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - scoreboard bench for sr_flag_arbiter with directed request vectors
module tb_sr_flag_arbiter;
    import sr_flag_pkg::*;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IW    = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [IW*NREQ-1:0] idx;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               busy;
    logic [NFLAG-1:0]   flags;
    logic               err;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .idx   (idx),
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy),
        .flags (flags),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {int who; logic [7:0] flags; logic err;} ack_t;
    typedef struct {int who; int gap;} gnt_t;

    ack_t ack_q[$];
    gnt_t gnt_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_gcyc   = -100;
    logic prev_busy   = 1'b0;
    logic sr_bad      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected grant on busy rising, the expected completion on ack/err.
    always @(negedge clk) begin
        gnt_t g;
        ack_t a;
        cyc++;
        if ((dut.w_s & dut.w_r) != '0) sr_bad = 1'b1;
        if (!rst) begin
            if (busy && !prev_busy) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_grant", 32'(gnt), 32'd0);
                end else begin
                    g = gnt_q.pop_front();
                    chk("grant", 32'(gnt), 32'(1 << g.who));
                    if (g.gap != 0) chk("grant_gap", cyc - last_gcyc, g.gap);
                end
                last_gcyc = cyc;
            end
            if (ack != '0 || err) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", {27'd0, err, ack}, 32'd0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack", 32'(ack), 32'(1 << a.who));
                    chk("ack_flags", 32'(flags), 32'(a.flags));
                    chk("ack_err", 32'(err), 32'(a.err));
                    chk("ack_latency", cyc - last_gcyc, 3);
                    chk("gnt_held_at_ack", 32'(gnt), 32'(1 << a.who));
                end
            end
        end
        prev_busy = busy;
    end

    // Requesters hold req until they see their ack, then drop it before the next edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req = req & ~ack;
        end
    endtask

    task automatic set_req(input int k, input logic [1:0] o, input int i);
        op[2*k +: 2]   = o;
        idx[IW*k +: IW] = IW'(i);
        req[k]         = 1'b1;
    endtask

    task automatic run_quiet();
        int n = 0;
        while ((req != '0 || busy || ack_q.size() != 0 || gnt_q.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        if (n >= 200) begin
            chk("timeout_quiet", 32'd1, 32'd0);
            ack_q.delete();
            gnt_q.delete();
            req = '0;
        end
    endtask

    initial begin
        logic [7:0] t3_flags [4];
        t3_flags = '{8'h01, 8'h03, 8'h07, 8'h0F};
        rst = 1'b1;
        req = '0;
        op  = '0;
        idx = '0;
        step(2);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        rst = 1'b0;

        set_req(0, OP_SET, 3);
        gnt_q.push_back('{0, 0});
        ack_q.push_back('{0, 8'h08, 1'b0});
        run_quiet();

        set_req(1, OP_TGL, 3);
        gnt_q.push_back('{1, 0});
        ack_q.push_back('{1, 8'h00, 1'b0});
        run_quiet();
        set_req(1, OP_TGL, 3);
        gnt_q.push_back('{1, 0});
        ack_q.push_back('{1, 8'h08, 1'b0});
        run_quiet();

        rst = 1'b1;
        step(1);
        chk("reset2_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(k, OP_SET, k);
            gnt_q.push_back('{k, (k == 0) ? 0 : 4});
            ack_q.push_back('{k, t3_flags[k], 1'b0});
        end
        run_quiet();

        set_req(2, OP_SET, 2);
        gnt_q.push_back('{2, 0});
        ack_q.push_back('{2, 8'h0F, 1'b0});
        run_quiet();
        set_req(1, OP_CLR, 0);
        set_req(2, OP_CLR, 1);
        gnt_q.push_back('{1, 0});
        gnt_q.push_back('{2, 4});
        ack_q.push_back('{1, 8'h0E, 1'b0});
        ack_q.push_back('{2, 8'h0C, 1'b0});
        run_quiet();

        set_req(0, OP_SET, 5);
        gnt_q.push_back('{0, 0});
        step(2);
        chk("hold_busy", 32'(busy), 32'd1);
        rst    = 1'b1;
        req[0] = 1'b0;
        step(1);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        step(4);
        set_req(3, OP_SET, 6);
        gnt_q.push_back('{3, 0});
        ack_q.push_back('{3, 8'h40, 1'b0});
        run_quiet();

        set_req(0, OP_NOP, 7);
        gnt_q.push_back('{0, 0});
        ack_q.push_back('{0, 8'h40, 1'b0});
        step(1);
        req[0]   = 1'b0;
        op[1:0]  = OP_SET;
        idx[2:0] = 3'd7;
        run_quiet();
        step(3);

        chk("no_s_and_r", 32'(sr_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
